// File: rtl/io_uart_bridge.sv
// io_uart_bridge: device endpoint for the CPU's 16-bit parallel I/O port.
// Bytes are handed over with toggle handshakes, buffered in TX/RX FIFOs, and
// exchanged with an external device as 8N1 serial frames on txd/rxd.
module io_uart_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ioOut,
  output logic [15:0] ioIn,
  output logic        txd,
  input  logic        rxd
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // CPU side
  logic [15:0] cpu_q;
  logic        tx_prev;
  logic        rx_prev;
  logic        ovr_flag;
  logic        fe_flag;
  logic        unused_cpu_bits;

  // TX FIFO and serializer
  logic [7:0]        tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  tx_wr;
  logic [PTR_W-1:0]  tx_rd;
  logic [CNT_W-1:0]  tx_count;
  logic [CNT_W-1:0]  tx_count_n;
  tx_state_t         tx_state;
  logic [BAUD_W-1:0] tx_baud;
  logic [2:0]        tx_bit;
  logic [7:0]        tx_shift;

  // RX FIFO and deserializer
  logic [7:0]        rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rx_wr;
  logic [PTR_W-1:0]  rx_rd;
  logic [PTR_W-1:0]  rx_rd_n;
  logic [CNT_W-1:0]  rx_count;
  logic [CNT_W-1:0]  rx_count_n;
  rx_state_t         rx_state;
  logic [BAUD_W-1:0] rx_baud;
  logic [2:0]        rx_bit;
  logic [7:0]        rx_shift;
  logic              rx_break;
  logic              rxd_s1;
  logic              rxd_s2;

  // Per-edge events
  logic       tx_req;
  logic       rx_req;
  logic       tx_full;
  logic       rx_full;
  logic       tx_pop;
  logic       tx_push;
  logic       tx_drop;
  logic       rx_pop;
  logic       rx_frame_done;
  logic       rx_push;
  logic       rx_drop;
  logic       fe_set;
  logic       ovr_n;
  logic       fe_n;
  logic [7:0] rx_head_n;

  // Port bits 12:8 carry nothing for this device
  assign unused_cpu_bits = ^cpu_q[12:8];

  // Decode handshake requests and FIFO traffic for the current edge
  always_comb begin
    tx_req  = cpu_q[15] != tx_prev;
    rx_req  = cpu_q[14] != rx_prev;
    tx_full = tx_count == CNT_FULL;
    rx_full = rx_count == CNT_FULL;

    // The serializer takes a byte whenever it is idle or just finishing a stop bit
    tx_pop  = (tx_count != '0) &&
              ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_baud == BAUD_LAST)));
    tx_push = tx_req && (!tx_full || tx_pop);
    tx_drop = tx_req && tx_full && !tx_pop;

    rx_pop        = rx_req && (rx_count != '0);
    rx_frame_done = (rx_state == RX_STOP) && !rx_break && (rx_baud == BAUD_LAST);
    rx_push       = rx_frame_done && rxd_s2 && (!rx_full || rx_pop);
    rx_drop       = rx_frame_done && rxd_s2 && rx_full && !rx_pop;
    fe_set        = rx_frame_done && !rxd_s2;
  end

  // Next FIFO occupancy, sticky flags and RX head as they will stand after this edge
  always_comb begin
    tx_count_n = tx_count;
    if (tx_push && !tx_pop) begin
      tx_count_n = tx_count + 1'b1;
    end else if (!tx_push && tx_pop) begin
      tx_count_n = tx_count - 1'b1;
    end

    rx_count_n = rx_count;
    if (rx_push && !rx_pop) begin
      rx_count_n = rx_count + 1'b1;
    end else if (!rx_push && rx_pop) begin
      rx_count_n = rx_count - 1'b1;
    end

    rx_rd_n = rx_pop ? rx_rd + 1'b1 : rx_rd;

    // A byte landing in an otherwise empty FIFO is not in memory yet, so bypass it
    if (rx_count_n == '0) begin
      rx_head_n = 8'h00;
    end else if (rx_push && (rx_rd_n == rx_wr)) begin
      rx_head_n = rx_shift;
    end else begin
      rx_head_n = rx_mem[rx_rd_n];
    end

    ovr_n = ovr_flag;
    fe_n  = fe_flag;
    if (cpu_q[13]) begin
      ovr_n = 1'b0;
      fe_n  = 1'b0;
    end
    if (tx_drop || rx_drop) begin
      ovr_n = 1'b1;
    end
    if (fe_set) begin
      fe_n = 1'b1;
    end
  end

  // Register the CPU word on every edge, reset or not
  always_ff @(posedge clk) begin
    cpu_q <= ioOut;
  end

  // Two-flop synchronizer for the asynchronous serial input
  always_ff @(posedge clk) begin
    if (!reset) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
    end
  end

  // Handshake state, FIFO pointers/counts, stickies and the registered ioIn word
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_prev  <= ioOut[15];
      rx_prev  <= ioOut[14];
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
      ovr_flag <= 1'b0;
      fe_flag  <= 1'b0;
      ioIn     <= {ioOut[15:14], 14'b0};
    end else begin
      tx_prev  <= cpu_q[15];
      rx_prev  <= cpu_q[14];
      if (tx_push) begin
        tx_wr <= tx_wr + 1'b1;
      end
      if (tx_pop) begin
        tx_rd <= tx_rd + 1'b1;
      end
      tx_count <= tx_count_n;
      if (rx_push) begin
        rx_wr <= rx_wr + 1'b1;
      end
      rx_rd    <= rx_rd_n;
      rx_count <= rx_count_n;
      ovr_flag <= ovr_n;
      fe_flag  <= fe_n;
      ioIn     <= {cpu_q[15], cpu_q[14], tx_count_n == CNT_FULL, rx_count_n != '0,
                   ovr_n, fe_n, 2'b00, rx_head_n};
    end
  end

  // TX FIFO storage write
  always_ff @(posedge clk) begin
    if (reset && tx_push) begin
      tx_mem[tx_wr] <= cpu_q[7:0];
    end
  end

  // RX FIFO storage write
  always_ff @(posedge clk) begin
    if (reset && rx_push) begin
      rx_mem[rx_wr] <= rx_shift;
    end
  end

  // TX serializer: start bit, 8 data bits LSB first, stop bit, chaining frames back to back
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_shift <= tx_mem[tx_rd];
            tx_baud  <= '0;
            txd      <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_baud == BAUD_LAST) begin
            tx_baud  <= '0;
            tx_bit   <= '0;
            txd      <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= TX_DATA;
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_baud == BAUD_LAST) begin
            tx_baud <= '0;
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              txd      <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_baud == BAUD_LAST) begin
            tx_baud <= '0;
            if (tx_pop) begin
              tx_shift <= tx_mem[tx_rd];
              txd      <= 1'b0;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          txd      <= 1'b1;
        end
      endcase
    end
  end

  // RX deserializer: mid-bit sampling, glitch rejection, framing-error recovery
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_break <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (!rxd_s2) begin
            rx_baud  <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_baud == BAUD_HALF) begin
            rx_baud <= '0;
            rx_bit  <= '0;
            if (!rxd_s2) begin
              rx_state <= RX_DATA;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_baud == BAUD_LAST) begin
            rx_baud  <= '0;
            rx_shift <= {rxd_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_break) begin
            if (rxd_s2) begin
              rx_break <= 1'b0;
              rx_state <= RX_IDLE;
            end
          end else if (rx_baud == BAUD_LAST) begin
            rx_baud <= '0;
            if (rxd_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_break <= 1'b1;
            end
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        default: begin
          rx_state <= RX_IDLE;
          rx_break <= 1'b0;
        end
      endcase
    end
  end

endmodule
